// File: rtl/serial_alu_4bit.sv
// rtl/serial_alu_4bit.sv - bit-serial ALU computing one result bit per cycle, LSB first
// Handshaked request/result interface; result and flags are held until consumed.
module serial_alu_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_ADD  = 3'b111
  } op_e;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, zero_q, in_ready_q, out_valid_q;

  logic             ai, bi, bit_d, carry_d;
  logic [WIDTH-1:0] result_d;

  always_comb begin
    ai      = a_q[cnt_q];
    bi      = b_q[cnt_q];
    carry_d = (ai & bi) | (ai & carry_q) | (bi & carry_q);
    bit_d   = 1'b0;
    case (op_q)
      OP_NOT:  bit_d = ~ai;
      OP_AND:  bit_d = ai & bi;
      OP_OR:   bit_d = ai | bi;
      OP_NAND: bit_d = ~(ai & bi);
      OP_NOR:  bit_d = ~(ai | bi);
      OP_XOR:  bit_d = ai ^ bi;
      OP_XNOR: bit_d = ~(ai ^ bi);
      OP_ADD:  bit_d = ai ^ bi ^ carry_q;
      default: bit_d = 1'b0;
    endcase
    result_d        = result_q;
    result_d[cnt_q] = bit_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_NOT;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= op_e'(op);
            a_q        <= a;
            b_q        <= b;
            result_q   <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          result_q <= result_d;
          // Carry only ever moves for ADD, so carry_out reads 0 for logical ops.
          carry_q  <= (op_q == OP_ADD) ? carry_d : 1'b0;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            zero_q      <= (result_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_alu_4bit.sv
// tb/tb_serial_alu_4bit.sv - directed self-checking bench for serial_alu_4bit
module tb_serial_alu_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] op;
  logic [3:0] a, b, result;
  logic       carry_out, zero;

  int tests = 0;
  int fails = 0;

  serial_alu_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .zero(zero)
  );

  always #5 clk = ~clk;

  // Starts at a falling edge; returns after the falling edge where out_valid rose (or timeout).
  task automatic do_op(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y, output int lat);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (result !== 4'b0000) begin fails++; $display("FAIL reset_result got %b exp 0000", result); end
    tests++; if (carry_out !== 1'b0 || zero !== 1'b0) begin fails++; $display("FAIL reset_flags got c=%b z=%b exp 0 0", carry_out, zero); end
  endtask

  task automatic test_add_example();
    int lat;
    rst_n = 1'b1;
    do_op(3'b111, 4'b1011, 4'b0110, lat);
    tests++; if (lat != 4) begin fails++; $display("FAIL add_latency got %0d exp 4", lat); end
    tests++; if (result !== 4'b0001) begin fails++; $display("FAIL add_result got %b exp 0001", result); end
    tests++; if (carry_out !== 1'b1) begin fails++; $display("FAIL add_carry got %b exp 1", carry_out); end
    tests++; if (zero !== 1'b0) begin fails++; $display("FAIL add_zero got %b exp 0", zero); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL add_done_in_ready got %b exp 0", in_ready); end
    consume();
  endtask

  task automatic test_xor_not();
    int lat;
    do_op(3'b101, 4'b1010, 4'b1010, lat);
    tests++; if (result !== 4'b0000) begin fails++; $display("FAIL xor_result got %b exp 0000", result); end
    tests++; if (zero !== 1'b1) begin fails++; $display("FAIL xor_zero got %b exp 1", zero); end
    tests++; if (carry_out !== 1'b0) begin fails++; $display("FAIL xor_carry got %b exp 0", carry_out); end
    consume();
    do_op(3'b000, 4'b0101, 4'b1111, lat);
    tests++; if (result !== 4'b1010) begin fails++; $display("FAIL not_result got %b exp 1010", result); end
    tests++; if (zero !== 1'b0 || carry_out !== 1'b0) begin fails++; $display("FAIL not_flags got c=%b z=%b exp 0 0", carry_out, zero); end
    consume();
  endtask

  task automatic test_all_ops();
    int lat;
    logic [3:0] x, y, er;
    logic       ec;
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 256; i++) begin
        x = i[7:4]; y = i[3:0]; ec = 1'b0;
        case (o)
          0: er = ~x;
          1: er = x & y;
          2: er = x | y;
          3: er = ~(x & y);
          4: er = ~(x | y);
          5: er = x ^ y;
          6: er = ~(x ^ y);
          default: {ec, er} = {1'b0, x} + {1'b0, y};
        endcase
        do_op(o[2:0], x, y, lat);
        tests++; if (lat != 4 || result !== er) begin fails++; $display("FAIL sweep_result op=%0d a=%b b=%b got %b lat=%0d exp %b lat=4", o, x, y, result, lat, er); end
        tests++; if (carry_out !== ec) begin fails++; $display("FAIL sweep_carry op=%0d a=%b b=%b got %b exp %b", o, x, y, carry_out, ec); end
        tests++; if (zero !== (er == 4'b0000)) begin fails++; $display("FAIL sweep_zero op=%0d a=%b b=%b got %b exp %b", o, x, y, zero, er == 4'b0000); end
        consume();
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    do_op(3'b111, 4'b1001, 4'b1000, lat);
    repeat (3) begin
      @(negedge clk);
      tests++; if (result !== 4'b0001 || carry_out !== 1'b1 || zero !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL hold_stable got r=%b c=%b z=%b v=%b rdy=%b exp 0001 1 0 1 0", result, carry_out, zero, out_valid, in_ready);
      end
    end
    in_valid = 1'b1; op = 3'b001; a = 4'b1111; b = 4'b1111;
    consume();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL hold_release got rdy=%b v=%b exp 1 0", in_ready, out_valid); end
    tests++; if (result !== 4'b0001 || carry_out !== 1'b1) begin fails++; $display("FAIL idle_keeps_result got r=%b c=%b exp 0001 1", result, carry_out); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL idle_out_ready got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_ignore_inputs();
    int lat;
    op = 3'b001; a = 4'b1100; b = 4'b1010; in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
      op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
    end
    tests++; if (lat != 4) begin fails++; $display("FAIL ignore_latency got %0d exp 4", lat); end
    tests++; if (result !== 4'b1000 || carry_out !== 1'b0) begin fails++; $display("FAIL ignore_result got r=%b c=%b exp 1000 0", result, carry_out); end
    in_valid = 1'b0;
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    op = 3'b111; a = 4'b1111; b = 4'b0001; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL midreset_hs got rdy=%b v=%b exp 1 0", in_ready, out_valid); end
    tests++; if (result !== 4'b0000 || carry_out !== 1'b0 || zero !== 1'b0) begin fails++; $display("FAIL midreset_out got r=%b c=%b z=%b exp 0000 0 0", result, carry_out, zero); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'b011, 4'b1100, 4'b1010, lat);
    tests++; if (lat != 4 || result !== 4'b0111) begin fails++; $display("FAIL midreset_nand got r=%b lat=%0d exp 0111 lat=4", result, lat); end
    tests++; if (carry_out !== 1'b0 || zero !== 1'b0) begin fails++; $display("FAIL midreset_nand_flags got c=%b z=%b exp 0 0", carry_out, zero); end
    consume();
  endtask

  initial begin
    test_reset();
    test_add_example();
    test_xor_not();
    test_hold();
    test_ignore_inputs();
    test_reset_mid();
    test_all_ops();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
